// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data BRAM port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        SRC_I,
        SRC_D
    } src_t;

    localparam logic [4:0] MEM_CODE_NONE      = 5'b00000;
    localparam logic [4:0] MEM_CODE_LW        = 5'b01111;
    localparam int         MEM_ADDR_LIMIT_BIT = 18;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU-side request/response handshakes plus the addresser-side bus of the arbiter.
interface mem_port_arbiter_if;

    logic        i_req_valid;
    logic        i_req_ready;
    logic [31:0] i_addr;
    logic        i_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] i_rsp_data;

    logic        d_req_valid;
    logic        d_req_ready;
    logic [31:0] d_addr;
    logic [4:0]  d_access_code;
    logic [31:0] d_wdata;
    logic        d_rsp_valid;
    logic        d_rsp_ready;
    logic [31:0] d_rsp_data;
    logic        d_rsp_error;

    logic [31:0] mem_address;
    logic [4:0]  mem_access_code;
    logic [31:0] mem_data_to_store;
    logic [31:0] mem_read_data;

    modport slave (
        input  i_req_valid, i_addr, i_rsp_ready,
        input  d_req_valid, d_addr, d_access_code, d_wdata, d_rsp_ready,
        input  mem_read_data,
        output i_req_ready, i_rsp_valid, i_rsp_data,
        output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_error,
        output mem_address, mem_access_code, mem_data_to_store
    );

    modport master (
        output i_req_valid, i_addr, i_rsp_ready,
        output d_req_valid, d_addr, d_access_code, d_wdata, d_rsp_ready,
        output mem_read_data,
        input  i_req_ready, i_rsp_valid, i_rsp_data,
        input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_error,
        input  mem_address, mem_access_code, mem_data_to_store
    );

endinterface

// File: rtl/mem_port_arbiter_priority.sv
// Winner selection between fetch and data requesters with a fetch starvation counter.
module mem_arb_priority #(
    parameter int I_MAX_WAIT = 4,
    parameter int WAIT_W     = 3
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              i_valid,
    input  logic              d_valid,
    input  logic              arbitrate,
    output logic              grant_i,
    output logic              grant_d,
    output logic [WAIT_W-1:0] wait_cnt
);

    localparam logic [WAIT_W-1:0] MAX_WAIT = WAIT_W'(I_MAX_WAIT);

    logic force_i;

    assign force_i = (wait_cnt == MAX_WAIT);
    assign grant_i = arbitrate && i_valid && (!d_valid || force_i);
    assign grant_d = arbitrate && d_valid && !grant_i;

    // Counts lost arbitrations of a continuously pending fetch.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if (!i_valid || grant_i) begin
            wait_cnt <= '0;
        end else if (arbitrate && !force_i) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the byte-lane BRAM addresser between fetch and data ports, one access per request.
// Optional out-of-range address check: define MEM_ARB_BOUNDARY_CHECK_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int I_MAX_WAIT = 4,
    parameter int WAIT_W     = 3
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    mem_port_arbiter_if.slave   bus,
    output logic                busy
);

    state_t            state;
    state_t            state_nxt;
    src_t              src;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_wdata;
    logic [4:0]        lat_code;
    logic              lat_err;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic [31:0]       req_addr;
    logic              addr_oor;
    logic              rsp_done;
    logic              arbitrate;
    logic              grant_i;
    logic              grant_d;
    logic [WAIT_W-1:0] wait_cnt;

    assign rsp_done  = (state == RESP) &&
                       ((src == SRC_I) ? bus.i_rsp_ready : bus.d_rsp_ready);
    assign arbitrate = resetn && ((state == IDLE) || rsp_done);
    assign req_addr  = grant_d ? bus.d_addr : bus.i_addr;

`ifdef MEM_ARB_BOUNDARY_CHECK_EN
    assign addr_oor = |req_addr[31:MEM_ADDR_LIMIT_BIT];
`else
    assign addr_oor = 1'b0;
`endif

    mem_arb_priority #(
        .I_MAX_WAIT (I_MAX_WAIT),
        .WAIT_W     (WAIT_W)
    ) u_prio (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .i_valid   (bus.i_req_valid),
        .d_valid   (bus.d_req_valid),
        .arbitrate (arbitrate),
        .grant_i   (grant_i),
        .grant_d   (grant_d),
        .wait_cnt  (wait_cnt)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            src       <= SRC_I;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_code  <= MEM_CODE_NONE;
            lat_err   <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            // Accept: out-of-range requests still take an access slot, but never touch memory.
            if (grant_i || grant_d) begin
                src       <= grant_d ? SRC_D : SRC_I;
                lat_addr  <= req_addr;
                lat_wdata <= grant_d ? bus.d_wdata : '0;
                lat_code  <= addr_oor ? MEM_CODE_NONE :
                             (grant_d ? bus.d_access_code : MEM_CODE_LW);
                lat_err   <= addr_oor;
            end
            // End of ACCESS: the BRAM read completed on the falling edge inside the cycle.
            if (state == ACCESS) begin
                rsp_data <= (lat_err || lat_code[4]) ? '0 : bus.mem_read_data;
                rsp_err  <= lat_err;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_i || grant_d) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    if (rsp_done) state_nxt = (grant_i || grant_d) ? ACCESS : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.i_req_ready       = grant_i;
    assign bus.d_req_ready       = grant_d;
    assign bus.i_rsp_valid       = (state == RESP) && (src == SRC_I);
    assign bus.d_rsp_valid       = (state == RESP) && (src == SRC_D);
    assign bus.i_rsp_data        = rsp_data;
    assign bus.d_rsp_data        = rsp_data;
    assign bus.d_rsp_error       = bus.d_rsp_valid && rsp_err;
    assign bus.mem_address       = lat_addr;
    assign bus.mem_data_to_store = lat_wdata;
    assign bus.mem_access_code   = (state == ACCESS) ? lat_code : MEM_CODE_NONE;
    assign busy                  = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a falling-edge word BRAM model behind the addresser bus.
module tb_mem_port_arbiter;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    logic busy;

    int errors   = 0;
    int checks   = 0;
    int n_writes = 0;

    logic [31:0] bram    [256];
    logic [31:0] ref_mem [256];
    rsp_t        i_q [$];
    rsp_t        d_q [$];

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .I_MAX_WAIT (4),
        .WAIT_W     (3)
    ) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bus      (bus),
        .busy     (busy)
    );

    function automatic logic oor(input logic [31:0] a);
`ifdef MEM_ARB_BOUNDARY_CHECK_EN
        return |a[31:18];
`else
        return 1'b0;
`endif
    endfunction

    // BRAM + addresser model: acts on the falling edge, word indexed by address[9:2]
    always @(negedge clk) begin : bram_model
        logic [31:0] w;
        if (bus.mem_access_code != 5'b00000) begin
            w = bram[bus.mem_address[9:2]];
            if (bus.mem_access_code[4]) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_access_code[b]) w[8*b +: 8] = bus.mem_data_to_store[8*b +: 8];
                bram[bus.mem_address[9:2]] = w;
                n_writes++;
            end
            bus.mem_read_data = w;
        end
    end

    // Scoreboard: pop on response handshake, push expectation on request accept
    always @(negedge clk) begin : scoreboard
        rsp_t e;
        logic [7:0] idx;
        if (resetn) begin
            if (bus.i_rsp_valid && bus.i_rsp_ready) begin
                checks++;
                if (i_q.size() == 0) begin
                    errors++;
                    $display("FAIL i_rsp_unexpected got=%h required=no response", bus.i_rsp_data);
                end else begin
                    e = i_q.pop_front();
                    if (bus.i_rsp_data !== e.data) begin
                        errors++;
                        $display("FAIL i_rsp_data got=%h required=%h", bus.i_rsp_data, e.data);
                    end
                end
            end
            if (bus.d_rsp_valid && bus.d_rsp_ready) begin
                checks++;
                if (d_q.size() == 0) begin
                    errors++;
                    $display("FAIL d_rsp_unexpected got=%h required=no response", bus.d_rsp_data);
                end else begin
                    e = d_q.pop_front();
                    if ({bus.d_rsp_data, bus.d_rsp_error} !== {e.data, e.err}) begin
                        errors++;
                        $display("FAIL d_rsp data/err got=%h/%b required=%h/%b",
                                 bus.d_rsp_data, bus.d_rsp_error, e.data, e.err);
                    end
                end
            end
            if (bus.i_req_valid && bus.i_req_ready) begin
                idx = bus.i_addr[9:2];
                i_q.push_back('{data: (oor(bus.i_addr) ? 32'h0 : ref_mem[idx]), err: 1'b0});
            end
            if (bus.d_req_valid && bus.d_req_ready) begin
                idx = bus.d_addr[9:2];
                if (oor(bus.d_addr)) begin
                    d_q.push_back('{data: 32'h0, err: 1'b1});
                end else if (bus.d_access_code[4]) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.d_access_code[b]) ref_mem[idx][8*b +: 8] = bus.d_wdata[8*b +: 8];
                    d_q.push_back('{data: 32'h0, err: 1'b0});
                end else begin
                    d_q.push_back('{data: ref_mem[idx], err: 1'b0});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        bram[idx]    = val;
        ref_mem[idx] = val;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!busy && i_q.size() == 0 && d_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle_timeout busy=%b pending=%0d required idle with none pending",
                     busy, i_q.size() + d_q.size());
        end
    endtask

    task automatic send_d(input logic [31:0] a, input logic [4:0] c, input logic [31:0] w);
        bit ok = 1'b0;
        bus.d_req_valid   = 1'b1;
        bus.d_addr        = a;
        bus.d_access_code = c;
        bus.d_wdata       = w;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            ok = bus.d_req_ready;
            tick();
        end
        bus.d_req_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL d_accept_timeout ready=0 required=1");
        end
    endtask

    task automatic send_i(input logic [31:0] a);
        bit ok = 1'b0;
        bus.i_req_valid = 1'b1;
        bus.i_addr      = a;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            ok = bus.i_req_ready;
            tick();
        end
        bus.i_req_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL i_accept_timeout ready=0 required=1");
        end
    endtask

    task automatic test_reset();
        bus.i_req_valid = 0; bus.i_addr = 0; bus.i_rsp_ready = 0;
        bus.d_req_valid = 0; bus.d_addr = 0; bus.d_access_code = 0;
        bus.d_wdata = 0; bus.d_rsp_ready = 0; bus.mem_read_data = 0;
        for (int k = 0; k < 256; k++) preload(k, 32'h0);
        #1 resetn = 1'b0;
        #1;
        checks++;
        if ({busy, bus.i_req_ready, bus.d_req_ready, bus.i_rsp_valid, bus.d_rsp_valid,
             bus.d_rsp_error} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b required=000000", {busy, bus.i_req_ready,
                     bus.d_req_ready, bus.i_rsp_valid, bus.d_rsp_valid, bus.d_rsp_error});
        end
        checks++;
        if (bus.mem_access_code !== 5'b0) begin
            errors++;
            $display("FAIL reset_code got=%b required=00000", bus.mem_access_code);
        end
        checks++;
        if ({bus.mem_address, bus.mem_data_to_store} !== 64'h0) begin
            errors++;
            $display("FAIL reset_mem_bus got=%h/%h required=0/0", bus.mem_address, bus.mem_data_to_store);
        end
        checks++;
        if ({bus.i_rsp_data, bus.d_rsp_data} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rsp_data got=%h/%h required=0/0", bus.i_rsp_data, bus.d_rsp_data);
        end
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        preload(4, 32'hDEADBEEF);
        bus.i_rsp_ready = 1'b1;
        bus.i_req_valid = 1'b1;
        bus.i_addr      = 32'h10;
        @(negedge clk);
        checks++;
        if ({bus.i_req_ready, bus.mem_access_code} !== {1'b1, 5'b00000}) begin
            errors++;
            $display("FAIL fetch_accept ready/code got=%b/%b required=1/00000",
                     bus.i_req_ready, bus.mem_access_code);
        end
        tick();
        bus.i_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.mem_access_code, bus.mem_address} !== {5'b01111, 32'h10}) begin
            errors++;
            $display("FAIL fetch_access code/addr got=%b/%h required=01111/00000010",
                     bus.mem_access_code, bus.mem_address);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus.i_rsp_valid, bus.i_rsp_data, bus.mem_access_code} !== {1'b1, 32'hDEADBEEF, 5'b0}) begin
            errors++;
            $display("FAIL fetch_resp valid/data/code got=%b/%h/%b required=1/deadbeef/00000",
                     bus.i_rsp_valid, bus.i_rsp_data, bus.mem_access_code);
        end
        tick();
        wait_idle();
    endtask

    task automatic test_store_load();
        int w0;
        preload(8, 32'h0);
        bus.d_rsp_ready = 1'b1;
        w0 = n_writes;
        send_d(32'h21, 5'b11111, 32'h11223344);
        @(negedge clk);
        checks++;
        if ({bus.mem_access_code, bus.mem_data_to_store} !== {5'b11111, 32'h11223344}) begin
            errors++;
            $display("FAIL store_access code/data got=%b/%h required=11111/11223344",
                     bus.mem_access_code, bus.mem_data_to_store);
        end
        tick();
        wait_idle();
        checks++;
        if (bram[8] !== 32'h11223344 || n_writes !== w0 + 1) begin
            errors++;
            $display("FAIL store_written word/writes got=%h/%0d required=11223344/%0d",
                     bram[8], n_writes, w0 + 1);
        end
        send_d(32'h21, 5'b01111, 32'h0);
        wait_idle();
        checks++;
        if (n_writes !== w0 + 1) begin
            errors++;
            $display("FAIL stray_write writes got=%0d required=%0d", n_writes, w0 + 1);
        end
    endtask

    task automatic test_starvation();
        logic exp_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        int   g = 0;
        logic got_i, got_d;
        for (int k = 0; k < 32; k++) preload(k, 32'h1000 + k);
        bus.i_rsp_ready   = 1'b1;
        bus.d_rsp_ready   = 1'b1;
        bus.i_addr        = 32'h0;
        bus.d_addr        = 32'h40;
        bus.d_access_code = 5'b01111;
        bus.i_req_valid   = 1'b1;
        bus.d_req_valid   = 1'b1;
        for (int cyc = 0; cyc < 80 && g < 10; cyc++) begin
            @(negedge clk);
            got_i = bus.i_req_ready;
            got_d = bus.d_req_ready;
            checks++;
            if (got_i && got_d) begin
                errors++;
                $display("FAIL both_granted ready_i/ready_d got=1/1 required one");
            end
            if (got_i) begin
                checks++;
                if (dut.u_prio.wait_cnt !== 3'd4) begin
                    errors++;
                    $display("FAIL forced_wait wait_cnt got=%0d required=4", dut.u_prio.wait_cnt);
                end
            end
            tick();
            if (got_i || got_d) begin
                checks++;
                if (got_d !== exp_d[g]) begin
                    errors++;
                    $display("FAIL grant_order #%0d d_won got=%b required=%b", g, got_d, exp_d[g]);
                end
                if (got_i) begin
                    checks++;
                    if (dut.u_prio.wait_cnt !== 3'd0) begin
                        errors++;
                        $display("FAIL wait_clear wait_cnt got=%0d required=0", dut.u_prio.wait_cnt);
                    end
                    bus.i_addr = bus.i_addr + 32'h4;
                end
                if (got_d) bus.d_addr = bus.d_addr + 32'h4;
                g++;
            end
        end
        bus.i_req_valid = 1'b0;
        bus.d_req_valid = 1'b0;
        checks++;
        if (g != 10) begin
            errors++;
            $display("FAIL starvation_timeout grants got=%0d required=10", g);
        end
        wait_idle();
    endtask

    task automatic test_back_pressure();
        bus.d_rsp_ready = 1'b0;
        bus.i_rsp_ready = 1'b1;
        send_d(32'h10, 5'b01111, 32'h0);
        tick();
        bus.i_req_valid = 1'b1;
        bus.i_addr      = 32'h14;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.d_rsp_valid, bus.d_rsp_data, bus.i_req_ready, bus.d_req_ready} !==
                {1'b1, ref_mem[4], 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL hold_resp valid/data/rdy_i/rdy_d got=%b/%h/%b/%b required=1/%h/0/0",
                         bus.d_rsp_valid, bus.d_rsp_data, bus.i_req_ready, bus.d_req_ready, ref_mem[4]);
            end
            tick();
        end
        bus.d_rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.i_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_accept i_req_ready got=%b required=1", bus.i_req_ready);
        end
        tick();
        bus.i_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.mem_access_code, bus.mem_address} !== {5'b01111, 32'h14}) begin
            errors++;
            $display("FAIL release_access code/addr got=%b/%h required=01111/00000014",
                     bus.mem_access_code, bus.mem_address);
        end
        tick();
        wait_idle();
    endtask

    task automatic test_reset_mid_access();
        preload(12, 32'hA5A5A5A5);
        bus.d_rsp_ready = 1'b1;
        send_d(32'h30, 5'b10001, 32'h000000FF);
        #1 resetn = 1'b0;
        #1;
        checks++;
        if ({bus.mem_access_code, busy, bus.i_rsp_valid, bus.d_rsp_valid, bus.i_req_ready,
             bus.d_req_ready} !== 10'b0) begin
            errors++;
            $display("FAIL reset_abort code/busy got=%b/%b required=00000/0",
                     bus.mem_access_code, busy);
        end
        d_q.delete();
        ref_mem[12] = 32'hA5A5A5A5;
        @(negedge clk);
        tick();
        checks++;
        if (bram[12] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL reset_abort_word got=%h required=a5a5a5a5", bram[12]);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_boundary();
        logic [4:0]  exp_code;
        logic [31:0] exp_word;
`ifdef MEM_ARB_BOUNDARY_CHECK_EN
        exp_code = 5'b00000;
        exp_word = 32'h12345678;
`else
        exp_code = 5'b11111;
        exp_word = 32'hCAFEF00D;
`endif
        preload(0, 32'h12345678);
        bus.d_rsp_ready = 1'b1;
        bus.i_rsp_ready = 1'b1;
        send_d(32'h00040000, 5'b11111, 32'hCAFEF00D);
        @(negedge clk);
        checks++;
        if (bus.mem_access_code !== exp_code) begin
            errors++;
            $display("FAIL boundary_code got=%b required=%b", bus.mem_access_code, exp_code);
        end
        tick();
        wait_idle();
        checks++;
        if (bram[0] !== exp_word) begin
            errors++;
            $display("FAIL boundary_word got=%h required=%h", bram[0], exp_word);
        end
        send_i(32'h00040000);
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_load();
        test_starvation();
        test_back_pressure();
        test_reset_mid_access();
        test_boundary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the byte-lane BRAM addresser between the instruction-fetch port and the data (load/store) port of the CPU. Accepts one request at a time over valid/ready handshakes, drives the addresser's address/access-code/store-data inputs for exactly one access cycle, captures the rotated read word, and returns it on a per-port response handshake. Data accesses have priority. A wait counter guarantees instruction fetch is never starved.

## Interface
- I_MAX_WAIT, 4: cycles a pending fetch may lose arbitration before it is forced to win (1..7).
- WAIT_W, 3: width of the starvation counter.

- CLOCK_50  in  1  system clock; rising edge is active for this block. The BRAMs sample on the falling edge.
- resetn  in  1  asynchronous, active-low reset.
- i_req_valid / i_req_ready  in / out  1  fetch request handshake.
- i_addr  in  32  fetch byte address; always a 32-bit word load.
- i_rsp_valid / i_rsp_ready  out / in  1  fetch response handshake.
- i_rsp_data  out  32  fetched word.
- d_req_valid / d_req_ready  in / out  1  data request handshake.
- d_addr  in  32  data byte address.
- d_access_code  in  5  bit 4 is store, bits [3:0] are byte enables.
- d_wdata  in  32  store data.
- d_rsp_valid / d_rsp_ready  out / in  1  data response handshake.
- d_rsp_data  out  32  load word; 0 for stores.
- d_rsp_error  out  1  out-of-range access. Tied 0 unless the boundary check is compiled in.
- mem_address  out  32  to addresser memory_address.
- mem_access_code  out  5  to addresser memory_access_code.
- mem_data_to_store  out  32  to addresser data_to_store.
- mem_read_data  in  32  from addresser writeback_register_data.
- busy  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: waiting for a request.
  - ACCESS: one cycle in which the latched request drives the mem_* outputs.
  - RESP: holding the response until the source accepts it.
- Arbitration occurs in IDLE, and in RESP in the same cycle that the response is accepted.
  - Default: d wins if d_req_valid.
  - i wins if i is the only requester, or if wait_cnt == I_MAX_WAIT.
- Accept: the winner's *_req_ready goes high combinationally in the arbitration cycle. The loser's ready is 0. Address, code, data and source are latched. Next state is ACCESS.
- wait_cnt:
  - Increments (saturating at I_MAX_WAIT) in each arbitration cycle where i_req_valid=1 and i loses.
  - Clears when i wins, or when i_req_valid=0.
- ACCESS:
  - mem_address = latched address.
  - mem_data_to_store = latched data.
  - mem_access_code = latched code. A fetch uses 5'b01111.
  - The BRAM write or read happens at the falling edge inside this cycle.
  - The rising edge that ends ACCESS captures mem_read_data into the response register and moves to RESP.
- Outside ACCESS, mem_access_code = 5'b00000, so no write can occur. mem_address and mem_data_to_store hold their last values.
- RESP:
  - Raise rsp_valid on the source port only.
  - rsp_data and rsp_error stay stable until the rsp_ready handshake.
  - Handshake with no new request goes to IDLE.
  - Handshake with a new request accepts it and goes straight to ACCESS.
- Stores return a response (data 0) so the pipeline can retire them in order.
- Simultaneous i and d valid in the same cycle: exactly one is accepted, and the other stays pending with its inputs held stable.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE, wait_cnt = 0.
  - All *_ready, *_rsp_valid, d_rsp_error and busy are 0.
  - mem_access_code = 0; mem_address and mem_data_to_store are 0.
  - Response registers are 0.
- Reset during ACCESS forces mem_access_code to 0 immediately, which aborts a pending store. An in-flight response is discarded.
- Latency: request accepted at edge N, ACCESS during cycle N+1, rsp_valid high from edge N+2.
- Peak throughput is one access per 2 cycles.
- *_req_ready may depend combinationally on *_req_valid and *_rsp_ready. No output depends combinationally on mem_read_data.

## Configuration
- MEM_ARB_BOUNDARY_CHECK_EN:
  - Defined: a request with address[31:18] != 0 still passes through ACCESS, but with mem_access_code forced to 0 (no write). It responds with data 0 and error=1. A fetch error is reported as i_rsp_data=0; the fetch port has no error flag.
  - Undefined: no check; upper address bits are ignored by the addresser, and d_rsp_error is tied 0.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the source enum (SRC_I, SRC_D);
  - MEM_CODE_NONE = 5'b00000;
  - MEM_CODE_LW = 5'b01111;
  - MEM_ADDR_LIMIT_BIT = 18.
- Sub-module mem_arb_priority holds the winner selection and the starvation counter. Inputs are both valids and the arbitrate strobe; outputs are grant_i, grant_d and wait_cnt.

## Test plan
- Fetch only, i_addr=0x10, BRAM word 0xDEADBEEF -> i_req_ready at N, mem_access_code=01111 only in N+1, i_rsp_data=0xDEADBEEF at N+2.
- Store d_addr=0x21, code 1_1111, d_wdata=0x11223344, then load same address -> d_rsp_data=0x11223344. No write when outside ACCESS.
- i and d valid together every cycle, I_MAX_WAIT=4 -> d wins 4 arbitrations, then i wins, then wait_cnt returns to 0.
- Hold d_rsp_ready=0 for 5 cycles -> d_rsp_valid and data held stable, no new accept. Release with i pending -> i accepted in the same cycle.
- Assert resetn=0 mid-ACCESS of a store -> mem_access_code=0 at once, target byte unchanged, all valids 0.
- With the macro defined, d_addr=0x00040000 store -> d_rsp_error=1, memory unchanged. Without the macro -> d_rsp_error=0.
